// File: rtl/clk_seq_pkg.sv
// clk_seq_pkg: definitions shared by the clock-enable sequencer and its channels.
//   - sequencer state encodings (HOLD, IDLE, RUN, STEP) in 2 bits
//   - hold_width(): width of the reset-hold counter for a given hold length
//   - div_slice(): extracts one channel divide value from the packed div_cfg bus
package clk_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_HOLD = 2'd0;
  localparam state_t ST_IDLE = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_STEP = 2'd3;

  // Upper bounds used by div_slice so a single non-parameterised function
  // serves every channel count and divide width (NUM_CH <= 8, DIV_W <= 32).
  localparam int unsigned MAX_DIV_W = 32;
  localparam int unsigned MAX_CFG_W = 256;

  // Counter width able to hold the value rst_hold (the HOLD_W of the top level).
  function automatic int unsigned hold_width(input int unsigned rst_hold);
    return $clog2(rst_hold + 1);
  endfunction

  // Channel ch's divide value of width w; the caller truncates to w bits.
  function automatic logic [MAX_DIV_W-1:0] div_slice(input logic [MAX_CFG_W-1:0] cfg,
                                                     input int unsigned          ch,
                                                     input int unsigned          w);
    logic [MAX_CFG_W-1:0] shifted;
    shifted = cfg >> (ch * w);
    return shifted[MAX_DIV_W-1:0];
  endfunction

endpackage

// File: rtl/clk_en_channel.sv
// clk_en_channel: one divided clock-enable channel.
// Counts advanced cycles from 0 up to the active divide value d and emits a
// one-cycle ch_en pulse on the wrap, giving a period of d+1 advanced cycles.
// A new divide value is first captured as pending; it becomes active either
// immediately while the sequencer is idle (idle_load) or at this channel's
// own wrap while running, so a reload never shortens or splits a period.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   advance     - 1 on cycles in which the sequencer advances
//   idle_load   - 1 while the sequencer is in IDLE or HOLD
//   cfg_load    - capture cfg_div into the pending register
//   cfg_div     - this channel's new divide value
//   ch_en       - registered enable pulse
module clk_en_channel
  import clk_seq_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             idle_load,
  input  logic             cfg_load,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             ch_en
);

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] act_r;
  logic [DIV_W-1:0] pend_r;
  logic             pend_valid_r;
  logic             ch_en_r;

  logic [DIV_W-1:0] cnt_nxt_s;
  logic [DIV_W-1:0] act_nxt_s;
  logic             en_nxt_s;
  logic             apply_s;

  // Next counter / active value / pulse; the pulse at a wrap still belongs to the old period.
  always_comb begin
    cnt_nxt_s = cnt_r;
    act_nxt_s = act_r;
    en_nxt_s  = 1'b0;
    apply_s   = 1'b0;
    if (advance) begin
      if (cnt_r == act_r) begin
        cnt_nxt_s = {DIV_W{1'b0}};
        en_nxt_s  = 1'b1;
        if (pend_valid_r) begin
          act_nxt_s = pend_r;
          apply_s   = 1'b1;
        end else begin
          act_nxt_s = act_r;
        end
      end else begin
        cnt_nxt_s = cnt_r + DIV_W'(1'b1);
      end
    end else if (idle_load && pend_valid_r) begin
      act_nxt_s = pend_r;
      cnt_nxt_s = {DIV_W{1'b0}};
      apply_s   = 1'b1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Channel state registers; a cfg_load coinciding with an apply keeps the new value pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= {DIV_W{1'b0}};
      act_r        <= {DIV_W{1'b0}};
      pend_r       <= {DIV_W{1'b0}};
      pend_valid_r <= 1'b0;
      ch_en_r      <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      act_r   <= act_nxt_s;
      ch_en_r <= en_nxt_s;
      if (cfg_load) begin
        pend_r       <= cfg_div;
        pend_valid_r <= 1'b1;
      end else if (apply_s) begin
        pend_r       <= pend_r;
        pend_valid_r <= 1'b0;
      end else begin
        pend_r       <= pend_r;
        pend_valid_r <= pend_valid_r;
      end
    end
  end

  assign ch_en = ch_en_r;

endmodule

// File: rtl/clk_en_sequencer.sv
// clk_en_sequencer: reset sequencing, run/halt/single-step control and
// NUM_CH divided clock-enable channels for the cache/CPU wrapper.
// After rst_n releases, sys_rst_n is held low for RST_HOLD cycles (HOLD),
// then the block idles until run (free-run) or step (one advanced cycle).
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   run        - level: 1 free-run, 0 halt
//   step       - pulse: one advanced cycle while halted
//   div_cfg    - packed per-channel divide values, channel i at [i*DIV_W +: DIV_W]
//   cfg_load   - pulse: capture div_cfg as pending divide values
//   ch_en      - per-channel enable pulses (registered)
//   sys_rst_n  - downstream active-low reset (registered)
//   running    - 1 while in RUN (registered)
//   cycle_cnt  - saturating count of advanced cycles
module clk_en_sequencer
  import clk_seq_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned RST_HOLD = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    step,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic                    cfg_load,
  output logic [NUM_CH-1:0]       ch_en,
  output logic                    sys_rst_n,
  output logic                    running,
  output logic [CNT_W-1:0]        cycle_cnt
);

  localparam int unsigned HOLD_W = hold_width(RST_HOLD);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic                hold_done_s;
  logic                advance_s;
  logic                idle_load_s;
  logic [CNT_W-1:0]    cycle_cnt_r;
  logic                running_r;
  logic                sys_rst_n_r;
  logic [MAX_CFG_W-1:0] cfg_ext_s;

  // HOLD ends on the RST_HOLD-th edge after rst_n releases.
  assign hold_done_s = (hold_cnt_r == HOLD_W'(RST_HOLD - 1));

  // Next state plus the advance / idle-load qualifiers handed to every channel.
  always_comb begin
    state_nxt_s = state_r;
    advance_s   = 1'b0;
    idle_load_s = 1'b0;
    case (state_r)
      ST_HOLD: begin
        idle_load_s = 1'b1;
        if (hold_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_IDLE: begin
        idle_load_s = 1'b1;
        if (run) begin
          state_nxt_s = ST_RUN;
        end else if (step) begin
          state_nxt_s = ST_STEP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // The cycle in which run is seen low is the halt cycle and does not advance.
        if (run) begin
          advance_s   = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STEP: begin
        advance_s   = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_HOLD;
      end
    endcase
  end

  // State and the status outputs derived from the next state, so they track state_r exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_HOLD;
      running_r   <= 1'b0;
      sys_rst_n_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      running_r   <= (state_nxt_s == ST_RUN);
      sys_rst_n_r <= (state_nxt_s != ST_HOLD);
    end
  end

  // Reset-hold counter; it freezes once HOLD is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else if ((state_r == ST_HOLD) && !hold_done_s) begin
      hold_cnt_r <= hold_cnt_r + HOLD_W'(1'b1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Advanced-cycle counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_r <= {CNT_W{1'b0}};
    end else if (advance_s && (cycle_cnt_r != {CNT_W{1'b1}})) begin
      cycle_cnt_r <= cycle_cnt_r + CNT_W'(1'b1);
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  assign cfg_ext_s = MAX_CFG_W'(div_cfg);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_s;
    assign div_s = DIV_W'(div_slice(cfg_ext_s, i, DIV_W));

    clk_en_channel #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (advance_s),
      .idle_load (idle_load_s),
      .cfg_load  (cfg_load),
      .cfg_div   (div_s),
      .ch_en     (ch_en[i])
    );
  end

  assign sys_rst_n = sys_rst_n_r;
  assign running   = running_r;
  assign cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_clk_en_sequencer.sv
// Directed bench for clk_en_sequencer: reset release, divide ratios,
// halt/step, live reload, simultaneous run+step with async reset, and
// cycle counter saturation on a CNT_W=4 build sharing the same stimulus.
module tb_clk_en_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic [31:0] div_cfg;
  logic        cfg_load;
  logic [3:0]  ch_en;
  logic        sys_rst_n;
  logic        running;
  logic [31:0] cycle_cnt;
  logic [3:0]  ch_en_sat;
  logic        sys_rst_n_sat;
  logic        running_sat;
  logic [3:0]  cycle_cnt_sat;

  int checks;
  int fails;

  clk_en_sequencer #(.NUM_CH(4), .DIV_W(8), .RST_HOLD(16), .CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .step      (step),
    .div_cfg   (div_cfg),
    .cfg_load  (cfg_load),
    .ch_en     (ch_en),
    .sys_rst_n (sys_rst_n),
    .running   (running),
    .cycle_cnt (cycle_cnt)
  );

  clk_en_sequencer #(.NUM_CH(4), .DIV_W(8), .RST_HOLD(16), .CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .step      (step),
    .div_cfg   (div_cfg),
    .cfg_load  (cfg_load),
    .ch_en     (ch_en_sat),
    .sys_rst_n (sys_rst_n_sat),
    .running   (running_sat),
    .cycle_cnt (cycle_cnt_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected enables after k advances from a cleared counter: channel i pulses when k is a multiple of d_i+1.
  function automatic logic [3:0] exp_en(input int k, input logic [31:0] cfg);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = int'(cfg[i*8 +: 8]);
      r[i] = (k > 0) && ((k % (d + 1)) == 0);
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; cfg_load = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (16) tick();
    checks++;
    if (sys_rst_n !== 1'b1 || sys_rst_n_sat !== 1'b1) begin
      fails++;
      $display("FAIL do_reset_release: sys_rst_n=%0b/%0b expected 1", sys_rst_n, sys_rst_n_sat);
    end
  endtask

  task automatic load_cfg(input logic [31:0] v);
    div_cfg = v; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; cfg_load = 1'b0; div_cfg = 32'h0;
    repeat (3) begin
      tick();
      checks++;
      if (sys_rst_n !== 1'b0 || ch_en !== 4'h0 || running !== 1'b0 || cycle_cnt !== 32'd0) begin
        fails++;
        $display("FAIL reset_state: sys_rst_n=%0b ch_en=%0h running=%0b cnt=%0d expected 0/0/0/0",
                 sys_rst_n, ch_en, running, cycle_cnt);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      checks++;
      if (sys_rst_n !== (e == 16) || ch_en !== 4'h0 || cycle_cnt !== 32'd0) begin
        fails++;
        $display("FAIL reset_hold edge %0d: sys_rst_n=%0b ch_en=%0h cnt=%0d expected %0b/0/0",
                 e, sys_rst_n, ch_en, cycle_cnt, (e == 16));
      end
    end
  endtask

  task automatic test_ratios;
    load_cfg(32'h07030100);
    run = 1'b1;
    tick();
    checks++;
    if (running !== 1'b1 || cycle_cnt !== 32'd0) begin
      fails++;
      $display("FAIL ratios_enter_run: running=%0b cnt=%0d expected 1/0", running, cycle_cnt);
    end
    for (int k = 1; k <= 32; k++) begin
      tick();
      checks++;
      if (ch_en !== exp_en(k, 32'h07030100) || cycle_cnt !== 32'(k)) begin
        fails++;
        $display("FAIL ratios k=%0d: ch_en=%0h cnt=%0d expected %0h/%0d",
                 k, ch_en, cycle_cnt, exp_en(k, 32'h07030100), k);
      end
    end
    run = 1'b0;
    tick();
    checks++;
    if (running !== 1'b0 || cycle_cnt !== 32'd32 || ch_en !== 4'h0) begin
      fails++;
      $display("FAIL ratios_halt: running=%0b cnt=%0d ch_en=%0h expected 0/32/0",
               running, cycle_cnt, ch_en);
    end
  endtask

  task automatic test_halt_step;
    do_reset();
    load_cfg(32'h07030100);
    run = 1'b1;
    tick();
    repeat (5) tick();
    run = 1'b0;
    tick();
    checks++;
    if (cycle_cnt !== 32'd5 || running !== 1'b0) begin
      fails++;
      $display("FAIL halt: cnt=%0d running=%0b expected 5/0", cycle_cnt, running);
    end
    for (int s = 1; s <= 3; s++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      checks++;
      if (running !== 1'b0 || ch_en !== 4'h0 || cycle_cnt !== 32'(4 + s)) begin
        fails++;
        $display("FAIL step_enter %0d: running=%0b ch_en=%0h cnt=%0d expected 0/0/%0d",
                 s, running, ch_en, cycle_cnt, 4 + s);
      end
      tick();
      checks++;
      if (running !== 1'b0 || cycle_cnt !== 32'(5 + s) || ch_en !== exp_en(5 + s, 32'h07030100)
          || ch_en[2] !== (s == 3)) begin
        fails++;
        $display("FAIL step_advance %0d: running=%0b cnt=%0d ch_en=%0h expected 0/%0d/%0h",
                 s, running, cycle_cnt, ch_en, 5 + s, exp_en(5 + s, 32'h07030100));
      end
      repeat (2) tick();
    end
    checks++;
    if (cycle_cnt !== 32'd8) begin
      fails++;
      $display("FAIL step_final: cnt=%0d expected 8", cycle_cnt);
    end
  endtask

  task automatic test_live_reload;
    logic [3:0] exp;
    do_reset();
    load_cfg(32'h03030303);
    run = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      tick();
      // After the 5th advance channel 0 sits at cnt=1; the load lands on the 6th advance.
      if (k == 5) begin
        div_cfg = 32'h03030301; cfg_load = 1'b1;
      end else begin
        cfg_load = 1'b0;
      end
      exp = exp_en(k, 32'h03030303);
      if (k > 8) exp[0] = ((k % 2) == 0);
      checks++;
      if (ch_en !== exp) begin
        fails++;
        $display("FAIL live_reload k=%0d: ch_en=%0h expected %0h", k, ch_en, exp);
      end
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] base;
    base = cycle_cnt;
    run = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (running !== 1'b1 || cycle_cnt !== base) begin
      fails++;
      $display("FAIL run_step_priority: running=%0b cnt=%0d expected 1/%0d", running, cycle_cnt, base);
    end
    tick();
    checks++;
    if (running !== 1'b1 || cycle_cnt !== base + 32'd1) begin
      fails++;
      $display("FAIL run_after_tie: running=%0b cnt=%0d expected 1/%0d", running, cycle_cnt, base + 32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sys_rst_n !== 1'b0 || running !== 1'b0 || ch_en !== 4'h0 || cycle_cnt !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: sys_rst_n=%0b running=%0b ch_en=%0h cnt=%0d expected 0/0/0/0",
               sys_rst_n, running, ch_en, cycle_cnt);
    end
    run = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (sys_rst_n !== 1'b0 || running !== 1'b0) begin
      fails++;
      $display("FAIL hold_reentered: sys_rst_n=%0b running=%0b expected 0/0", sys_rst_n, running);
    end
  endtask

  task automatic test_saturation;
    int e;
    do_reset();
    load_cfg(32'h07030100);
    run = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      e = (k > 15) ? 15 : k;
      checks++;
      if (cycle_cnt_sat !== 4'(e) || ch_en_sat !== exp_en(k, 32'h07030100) || running_sat !== 1'b1) begin
        fails++;
        $display("FAIL saturation k=%0d: cnt=%0d ch_en=%0h running=%0b expected %0d/%0h/1",
                 k, cycle_cnt_sat, ch_en_sat, running_sat, e, exp_en(k, 32'h07030100));
      end
    end
    run = 1'b0;
    tick();
    checks++;
    if (cycle_cnt_sat !== 4'd15 || cycle_cnt !== 32'd20) begin
      fails++;
      $display("FAIL saturation_hold: cnt_sat=%0d cnt=%0d expected 15/20", cycle_cnt_sat, cycle_cnt);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; cfg_load = 1'b0; div_cfg = 32'h0;
    test_reset();
    test_ratios();
    test_halt_step();
    test_live_reload();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clk_en_sequencer.md
Name: clk_en_sequencer

Overview:
- Synthesizable successor to the free-running single-clock stimulus that drives the cache/CPU wrapper.
- Generates NUM_CH independent divided clock-enable pulses from one clock, each with its own ratio. Ratios are reloadable without glitches.
- Sequences the system reset release and adds run / halt / single-step control, so the cache/CPU core can be paused and stepped.
- Keeps a saturating cycle counter. Sits between the board clock/reset and the cache_cpu_design wrapper.

Parameters:
- NUM_CH, 4: number of clock-enable channels (1..8).
- DIV_W, 8: width of each channel divide value.
- RST_HOLD, 16: cycles sys_rst_n is held low after rst_n deasserts (>=1).
- CNT_W, 32: width of cycle_cnt.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = free-run, 0 = halt.
- step  in  1  single-cycle pulse; advances one cycle while halted.
- div_cfg  in  NUM_CH*DIV_W  channel i divide value at bits [i*DIV_W +: DIV_W].
- cfg_load  in  1  single-cycle pulse; captures div_cfg into the pending registers.
- ch_en  out  NUM_CH  registered per-channel enable pulse.
- sys_rst_n  out  1  registered active-low reset to downstream logic.
- running  out  1  registered; 1 while in state RUN.
- cycle_cnt  out  CNT_W  number of advanced cycles since reset, saturating.

Behaviour:
- Reset (rst_n=0, async):
  - state=HOLD; sys_rst_n=0, ch_en=0, running=0, cycle_cnt=0.
  - All channel counters=0; active and pending divide values = 0; pend_valid=0.
- States and transitions:
  - HOLD: hold counter counts up. Leave HOLD after RST_HOLD cycles with rst_n high, going to IDLE with sys_rst_n=1. Nothing advances in HOLD.
  - IDLE: run=1 -> RUN. Otherwise step=1 -> STEP. Otherwise stay.
  - RUN: advance every cycle. run=0 -> IDLE at the next edge; that cycle does not advance.
  - STEP: advance exactly once, then IDLE, independent of run and step.
- Simultaneous run=1 and step=1 in IDLE: run wins, go to RUN. A step seen in RUN or HOLD is ignored.
- "Advance" applies per channel i, with active divide value d_i:
  - If cnt_i==d_i: cnt_i<=0 and ch_en[i]<=1.
  - Else: cnt_i<=cnt_i+1 and ch_en[i]<=0.
  - In any non-advancing cycle, ch_en[i]<=0 and cnt_i holds.
  - Result: period is d_i+1 advanced cycles; d_i=0 gives ch_en high on every advanced cycle.
- First-pulse timing: ch_en[i] rises at the (d_i+1)th advancing edge after cnt_i=0. Example: d=3, RUN entered at edge E, advances at E+1..E+4, ch_en high after E+4 for one cycle.
- running=1 exactly while state=RUN.
- cycle_cnt: +1 on each advancing edge. Saturates at all-ones and never wraps.
- cfg_load:
  - Latches div_cfg into the pending registers and sets pend_valid for every channel.
  - In IDLE or HOLD: pending values are copied to active at the next edge and cnt_i is cleared.
  - In RUN or STEP: channel i copies pending to active at the same edge as its own wrap (cnt_i==d_i). The pulse at that wrap belongs to the old period. This makes reloads glitch-free.
  - A second cfg_load before apply overwrites the pending values; only the last one applies.
- Counter overflow is impossible because cnt_i never exceeds d_i. cnt_i is DIV_W bits wide.
- rst_n asserted mid-operation forces every register to its reset value immediately.

Decomposition:
- Shared package clk_seq_pkg holds:
  - state enum: HOLD, IDLE, RUN, STEP, 2 bits;
  - localparam HOLD_W = $clog2(RST_HOLD+1);
  - a helper function that extracts the channel slice from div_cfg.
- One sub-module, clk_en_channel: per-channel counter, active and pending divide registers, wrap compare and ch_en flop. It takes advance, idle_load and cfg_load inputs.
- The top level contains the FSM, hold counter and cycle_cnt, and a generate loop over NUM_CH instances of clk_en_channel.

Test Plan:
- Reset release: rst_n low 3 cycles then high, RST_HOLD=16 -> sys_rst_n stays 0 for 16 edges, rises at the 16th; ch_en=0 and cycle_cnt=0 throughout.
- Ratios: cfg_load with div values 0,1,3,7 in IDLE, then run=1 for 32 cycles -> ch_en[0] high every cycle, [1] every 2nd, [2] every 4th, [3] every 8th; cycle_cnt=32 after run drops, running falls one edge later.
- Halt and step: after 5 RUN cycles with d=3, set run=0, then pulse step 3 times spaced 4 cycles apart -> cycle_cnt goes 5->8, ch_en[2] pulses on the 3rd step only, running stays 0.
- Live reload: channel 0 at d=3 in RUN, cfg_load d=1 when cnt=1 -> pulses continue at period 4 until the next wrap, then period 2; no pulse is skipped or doubled.
- Simultaneous run and step in IDLE -> RUN entered, no separate STEP cycle. Then rst_n pulled low mid-RUN -> all outputs 0 at once (async), HOLD re-entered.
- Saturation: CNT_W=4 build, run 20 cycles -> cycle_cnt reaches 15 and holds at 15.
